// File: rtl/ahb_slave_arbiter_pkg.sv
// Shared types and helpers for the per-slave AHB arbiter.
//   htrans_e       : HTRANS encodings
//   hburst_e       : HBURST encodings
//   arb_state_e    : arbiter FSM states
//   burst_beats_m1 : fixed-length burst size minus one (0 for SINGLE/INCR)
//   mid_width      : owner index width, never below 1
package ahb_slave_arbiter_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'd0,
      HTRANS_BUSY   = 2'd1,
      HTRANS_NONSEQ = 2'd2,
      HTRANS_SEQ    = 2'd3
   } htrans_e;

   typedef enum logic [2:0] {
      HBURST_SINGLE = 3'd0,
      HBURST_INCR   = 3'd1,
      HBURST_WRAP4  = 3'd2,
      HBURST_INCR4  = 3'd3,
      HBURST_WRAP8  = 3'd4,
      HBURST_INCR8  = 3'd5,
      HBURST_WRAP16 = 3'd6,
      HBURST_INCR16 = 3'd7
   } hburst_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_OWNED  = 2'd1,
      ST_BURST  = 2'd2,
      ST_LOCKED = 2'd3
   } arb_state_e;

   localparam int BURST_CNT_W = 4;

   function automatic logic [BURST_CNT_W-1:0] burst_beats_m1(input hburst_e hburst);
      logic [BURST_CNT_W-1:0] beats;
      case (hburst)
         HBURST_WRAP4,  HBURST_INCR4:  beats = 4'd3;
         HBURST_WRAP8,  HBURST_INCR8:  beats = 4'd7;
         HBURST_WRAP16, HBURST_INCR16: beats = 4'd15;
         default:                      beats = 4'd0;
      endcase
      return beats;
   endfunction

   function automatic int mid_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/ahb_slave_arbiter_if.sv
// Bus bundle between the master-side request logic and the slave arbiter.
//   req/htrans/hburst/hmastlock : per-channel address-phase request info
//   hready                      : HREADYOUT of the slave
//   sel_addr/sel_data           : one-hot address/data phase selects
//   hmaster/grant_vld           : current owner index and owner-valid flag
// Modports: master = request/ready driver side, slave = arbiter side.
interface ahb_slave_arbiter_if
   import ahb_slave_arbiter_pkg::*;
#(
   parameter int CHANNEL_NUM = 2
);
   localparam int MID_W = mid_width(CHANNEL_NUM);

   logic [CHANNEL_NUM-1:0]       req;
   logic [CHANNEL_NUM-1:0][1:0]  htrans;
   logic [CHANNEL_NUM-1:0][2:0]  hburst;
   logic [CHANNEL_NUM-1:0]       hmastlock;
   logic                         hready;
   logic [CHANNEL_NUM-1:0]       sel_addr;
   logic [CHANNEL_NUM-1:0]       sel_data;
   logic [MID_W-1:0]             hmaster;
   logic                         grant_vld;

   modport master (
      output req, htrans, hburst, hmastlock, hready,
      input  sel_addr, sel_data, hmaster, grant_vld
   );

   modport slave (
      input  req, htrans, hburst, hmastlock, hready,
      output sel_addr, sel_data, hmaster, grant_vld
   );

endinterface

// File: rtl/ahb_slave_arbiter_pick.sv
// Combinational winner selection for the slave arbiter (module ahb_arb_pick).
//   req     : per-channel request vector
//   rr_ptr  : round-robin search start (only with AHB_ARB_ROUND_ROBIN_EN)
//   gnt     : one-hot winner, all-zero when nobody requests
//   gnt_idx : winner index
//   gnt_any : at least one request present
// Macro AHB_ARB_ROUND_ROBIN_EN selects round-robin; otherwise the lowest
// requesting index wins.
module ahb_arb_pick
   import ahb_slave_arbiter_pkg::*;
#(
   parameter int CHANNEL_NUM = 2,
   parameter int MID_W       = mid_width(CHANNEL_NUM)
) (
   input  logic [CHANNEL_NUM-1:0] req,
`ifdef AHB_ARB_ROUND_ROBIN_EN
   input  logic [MID_W-1:0]       rr_ptr,
`endif
   output logic [CHANNEL_NUM-1:0] gnt,
   output logic [MID_W-1:0]       gnt_idx,
   output logic                   gnt_any
);

`ifdef AHB_ARB_ROUND_ROBIN_EN
   always_comb begin
      int cand;
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      cand    = 0;
      for (int k = 0; k < CHANNEL_NUM; k++) begin
         // walk the ring starting at rr_ptr; subtraction keeps the wrap exact
         // for channel counts that are not a power of two
         cand = int'(rr_ptr) + k;
         if (cand >= CHANNEL_NUM) cand = cand - CHANNEL_NUM;
         if (!gnt_any && req[cand]) begin
            gnt_any   = 1'b1;
            gnt[cand] = 1'b1;
            gnt_idx   = MID_W'(cand);
         end
      end
   end
`else
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      gnt_any = 1'b0;
      for (int k = 0; k < CHANNEL_NUM; k++) begin
         if (!gnt_any && req[k]) begin
            gnt_any = 1'b1;
            gnt[k]  = 1'b1;
            gnt_idx = MID_W'(k);
         end
      end
   end
`endif

endmodule

// File: rtl/ahb_slave_arbiter.sv
// Per-slave arbiter of the multi-layer AHB interconnect. Produces the
// registered one-hot address-phase select for the slave payload mux and the
// one-cycle-delayed data-phase select for HWDATA / response routing.
// Ownership is held across fixed-length bursts, undefined-length INCR bursts
// and locked sequences; all registers update only when hready is high.
//   HCLK    : interconnect clock
//   HRESETn : asynchronous active-low reset
//   bus     : ahb_slave_arbiter_if.slave (requests in, selects out)
// Macro AHB_ARB_ROUND_ROBIN_EN: round-robin arbitration (default: fixed
// priority, lowest index wins).
//
// state     | meaning
// ----------+---------------------------------------------------------------
// ST_IDLE   | no owner, sel_addr = 0, grant on any request
// ST_OWNED  | owner on a single transfer or last beat; next move decided here
// ST_BURST  | fixed-length burst in flight, burst_cnt = SEQ beats remaining
// ST_LOCKED | owner holds HMASTLOCK, grant frozen until it drops
module ahb_slave_arbiter
   import ahb_slave_arbiter_pkg::*;
#(
   parameter int CHANNEL_NUM = 2
) (
   input  logic                HCLK,
   input  logic                HRESETn,
   ahb_slave_arbiter_if.slave  bus
);

   localparam int MID_W = mid_width(CHANNEL_NUM);

   arb_state_e              state_q, state_d;
   logic [BURST_CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
   logic [CHANNEL_NUM-1:0]  sel_addr_q, sel_addr_d;
   logic [CHANNEL_NUM-1:0]  sel_data_q, sel_data_d;
   logic [MID_W-1:0]        hmaster_q, hmaster_d;
   logic                    grant_vld_q, grant_vld_d;

   logic [CHANNEL_NUM-1:0]  pick_gnt;
   logic [MID_W-1:0]        pick_idx;
   logic                    pick_any;

   htrans_e                 own_trans;
   hburst_e                 own_burst;
   logic                    own_lock;
   logic                    eval_owned;
   logic                    arbitrate;

`ifdef AHB_ARB_ROUND_ROBIN_EN
   logic [MID_W-1:0]        rr_ptr_q, rr_ptr_d;
`endif

   ahb_arb_pick #(
      .CHANNEL_NUM (CHANNEL_NUM),
      .MID_W       (MID_W)
   ) u_pick (
      .req     (bus.req),
`ifdef AHB_ARB_ROUND_ROBIN_EN
      .rr_ptr  (rr_ptr_q),
`endif
      .gnt     (pick_gnt),
      .gnt_idx (pick_idx),
      .gnt_any (pick_any)
   );

   assign own_trans = htrans_e'(bus.htrans[hmaster_q]);
   assign own_burst = hburst_e'(bus.hburst[hmaster_q]);
   assign own_lock  = bus.hmastlock[hmaster_q];

   always_comb begin
      state_d     = state_q;
      burst_cnt_d = burst_cnt_q;
      sel_addr_d  = sel_addr_q;
      sel_data_d  = sel_data_q;
      hmaster_d   = hmaster_q;
      grant_vld_d = grant_vld_q;
`ifdef AHB_ARB_ROUND_ROBIN_EN
      rr_ptr_d    = rr_ptr_q;
`endif
      eval_owned  = 1'b0;
      arbitrate   = 1'b0;

      if (bus.hready) begin
         // data phase follows the address phase that was just accepted
         sel_data_d = (own_trans == HTRANS_NONSEQ || own_trans == HTRANS_SEQ) ?
                      sel_addr_q : '0;

         unique case (state_q)
            ST_IDLE:   arbitrate  = 1'b1;
            ST_OWNED:  eval_owned = 1'b1;
            ST_BURST: begin
               case (own_trans)
                  HTRANS_SEQ: begin
                     if (burst_cnt_q <= BURST_CNT_W'(1)) begin
                        burst_cnt_d = '0;
                        // a lock raised on the last beat keeps the grant
                        state_d     = own_lock ? ST_LOCKED : ST_OWNED;
                     end else begin
                        burst_cnt_d = burst_cnt_q - BURST_CNT_W'(1);
                     end
                  end
                  HTRANS_BUSY: ;
                  default: begin
                     // early termination: treat this cycle as a fresh decision
                     burst_cnt_d = '0;
                     eval_owned  = 1'b1;
                  end
               endcase
            end
            ST_LOCKED: if (!own_lock) state_d = ST_OWNED;
         endcase

         if (eval_owned) begin
            if (own_trans == HTRANS_NONSEQ &&
                burst_beats_m1(own_burst) != '0) begin
               burst_cnt_d = burst_beats_m1(own_burst);
               state_d     = ST_BURST;
            end else if (own_trans == HTRANS_SEQ || own_trans == HTRANS_BUSY ||
                         (own_trans == HTRANS_NONSEQ && own_burst == HBURST_INCR)) begin
               // undefined-length INCR: keep the owner until IDLE or a new NONSEQ
               state_d = ST_OWNED;
            end else if (own_lock) begin
               state_d = ST_LOCKED;
            end else begin
               arbitrate = 1'b1;
            end
         end

         if (arbitrate) begin
            if (pick_any) begin
               sel_addr_d  = pick_gnt;
               hmaster_d   = pick_idx;
               grant_vld_d = 1'b1;
               state_d     = ST_OWNED;
`ifdef AHB_ARB_ROUND_ROBIN_EN
               rr_ptr_d    = (pick_idx == MID_W'(CHANNEL_NUM - 1)) ?
                             '0 : pick_idx + MID_W'(1);
`endif
            end else begin
               sel_addr_d  = '0;
               grant_vld_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= ST_IDLE;
         burst_cnt_q <= '0;
         sel_addr_q  <= '0;
         sel_data_q  <= '0;
         hmaster_q   <= '0;
         grant_vld_q <= 1'b0;
`ifdef AHB_ARB_ROUND_ROBIN_EN
         rr_ptr_q    <= '0;
`endif
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         sel_addr_q  <= sel_addr_d;
         sel_data_q  <= sel_data_d;
         hmaster_q   <= hmaster_d;
         grant_vld_q <= grant_vld_d;
`ifdef AHB_ARB_ROUND_ROBIN_EN
         rr_ptr_q    <= rr_ptr_d;
`endif
      end
   end

   assign bus.sel_addr  = sel_addr_q;
   assign bus.sel_data  = sel_data_q;
   assign bus.hmaster   = hmaster_q;
   assign bus.grant_vld = grant_vld_q;

endmodule

// File: doc/ahb_slave_arbiter.md
Name: ahb_slave_arbiter

Overview:
- Per-slave arbiter for the multi-layer AHB interconnect.
- Produces the one-hot channel select that drives the slave-side payload mux. That mux forwards 78-bit master payloads (HADDR/HWDATA/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK) to one slave.
- Also produces the delayed data-phase select that routes HWDATA and the slave response back to the owning master.
- Holds ownership across fixed-length bursts and locked sequences. Re-arbitrates only at legal AHB boundaries.

Parameters:
- CHANNEL_NUM, 2, number of master channels competing for this slave (2..16).
- MID_W, $clog2(CHANNEL_NUM) (min 1), width of the owner index.

Ports:
- HCLK  input  1  interconnect clock, rising-edge.
- HRESETn  input  1  asynchronous active-low reset.
- req  input  CHANNEL_NUM  bit i: master channel i presents an address-phase transfer decoded to this slave.
- htrans  input  CHANNEL_NUM x 2  per-channel HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- hburst  input  CHANNEL_NUM x 3  per-channel HBURST.
- hmastlock  input  CHANNEL_NUM  per-channel HMASTLOCK.
- hready  input  1  HREADYOUT from the slave. High means the current data phase completes this cycle.
- sel_addr  output  CHANNEL_NUM  registered one-hot address-phase select, or all-zero when no owner. Feeds the payload mux sel.
- sel_data  output  CHANNEL_NUM  registered one-hot data-phase select, or all-zero.
- hmaster  output  MID_W  index of the current address-phase owner. Valid when sel_addr != 0.
- grant_vld  output  1  high when sel_addr != 0.

Behaviour:
- Reset (async assert, sync release): sel_addr=0, sel_data=0, hmaster=0, grant_vld=0, burst_cnt=0, state=IDLE, rr_ptr=0.
- All outputs are registered. A grant decision made in cycle N appears at cycle N+1.
- Updates occur only on edges where hready=1. When hready=0, every register holds its value.
- Owner signals below are htrans/hburst/hmastlock indexed by hmaster.
- States:
  - IDLE: sel_addr=0. If any req, grant the arbitration winner and go to OWNED.
  - OWNED: the owner may be in the last beat or a single transfer.
    - Owner NONSEQ with hburst INCR4/WRAP4 loads burst_cnt=3; INCR8/WRAP8 loads 7; INCR16/WRAP16 loads 15. Go to BURST.
    - Else if owner hmastlock=1, go to LOCKED.
    - Else re-arbitrate. The winner may be the same master. No req returns to IDLE.
  - BURST: each hready=1 cycle with owner SEQ decrements burst_cnt. BUSY holds the count. Reaching 0 goes to OWNED.
    - Owner IDLE or NONSEQ (early termination) clears burst_cnt and re-evaluates as OWNED in the same cycle.
  - LOCKED: grant is held while owner hmastlock=1. When the owner deasserts the lock, go to OWNED.
- INCR (undefined length): ownership is held while the owner presents SEQ or BUSY. Re-arbitration happens at owner IDLE or NONSEQ.
- sel_data: on hready=1, sel_data <= sel_addr if owner htrans is NONSEQ or SEQ, else 0.
- Simultaneous events:
  - A req from another master never pre-empts BURST or LOCKED.
  - A lock asserted on the final burst beat gives LOCKED precedence over OWNED.
- Owner index is computed modulo CHANNEL_NUM. burst_cnt is 4 bits.

Optional Feature:
- Macro: AHB_ARB_ROUND_ROBIN_EN.
- Defined: round-robin arbitration. Search starts at rr_ptr. After each grant, rr_ptr = granted index + 1, wrapping at CHANNEL_NUM.
- Undefined: fixed priority, lowest requesting index wins. rr_ptr is removed.

Decomposition:
- Shared package (AHB_package):
  - HTRANS/HBURST enum typedefs.
  - arbiter state enum.
  - burst-length lookup function (hburst -> beats-1).
- One sub-module: ahb_arb_pick. Combinational one-hot winner selection from req plus the optional rr_ptr, implementing both modes under the macro.

Test Plan:
- Reset mid-burst: assert HRESETn=0 during an INCR8 beat 3 -> sel_addr=0, sel_data=0, grant_vld=0 immediately. After release with no req, outputs stay 0.
- Single transfers, CHANNEL_NUM=2, req=2'b11 every cycle with NONSEQ SINGLE:
  - RR build: sel_addr alternates 01,10,01,...
  - Fixed build: sel_addr stays 01.
- Burst hold: ch0 NONSEQ INCR4 then 3 SEQ beats, ch1 req=1 throughout -> sel_addr=01 for 4 address beats, then 10. sel_data lags sel_addr by one hready cycle.
- Wait states: hready=0 for 3 cycles during ch0 WRAP8 beat 2 -> sel_addr, sel_data and burst_cnt frozen. Burst completes after 8 accepted beats.
- Lock: ch1 hmastlock=1 across two SINGLE transfers while ch0 requests -> sel_addr=10 until the lock drops, then 01.
- Early termination: ch0 INCR16 issues NONSEQ after 5 SEQ beats with ch1 requesting -> burst_cnt cleared, arbitration runs that cycle, ch1 granted next (RR build).
